// File: rtl/idelay_ctrl_pkg.sv
// rtl/idelay_ctrl_pkg.sv - shared states, request ops and constants for the IDELAYE2 tap controller
// Readback checking is enabled in the top level by defining IDELAY_READBACK_EN.
package idelay_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_RDY = 3'd0;
    localparam state_t ST_SETTLE   = 3'd1;
    localparam state_t ST_APPLY    = 3'd2;
    localparam state_t ST_IDLE     = 3'd3;
    localparam state_t ST_EXEC     = 3'd4;
    localparam state_t ST_GAP      = 3'd5;
    localparam state_t ST_VERIFY   = 3'd6;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_INC      = 2'b01,
        OP_DEC      = 2'b10,
        OP_LOAD_ALL = 2'b11
    } op_e;

    localparam int VERIFY_WAIT = 2;

endpackage

// File: rtl/idelay_settle_timer.sv
// rtl/idelay_settle_timer.sv - counts consecutive IDELAYCTRL-ready cycles, restarting whenever ready drops
module idelay_settle_timer #(
    parameter int CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rdy,
    output logic o_done
);

    localparam int CNT_W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_rdy) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= CNT_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/rgmii_idelay_tap_ctrl.sv
// rtl/rgmii_idelay_tap_ctrl.sv - runtime per-lane IDELAYE2 VAR_LOAD tap controller for RGMII receive
// Optional CNTVALUEOUT readback check after each op when IDELAY_READBACK_EN is defined.
module rgmii_idelay_tap_ctrl
    import idelay_ctrl_pkg::*;
#(
    parameter int NUM_LANES     = 5,
    parameter int TAP_WIDTH     = 5,
    parameter int DEFAULT_TAP   = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_ictrl_rdy,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [1:0]                     i_req_op,
    input  logic [LANE_W-1:0]              i_req_lane,
    input  logic [TAP_WIDTH-1:0]           i_req_tap,
    output logic [NUM_LANES-1:0]           o_idelay_ld,
    output logic [NUM_LANES-1:0]           o_idelay_ce,
    output logic                           o_idelay_inc,
    output logic [NUM_LANES*TAP_WIDTH-1:0] o_idelay_cntvaluein,
    input  logic [NUM_LANES*TAP_WIDTH-1:0] i_idelay_cntvalueout,
    output logic [NUM_LANES*TAP_WIDTH-1:0] o_tap_shadow,
    output logic                           o_init_done,
    output logic                           o_sat,
    output logic                           o_err
);

    localparam logic [TAP_WIDTH-1:0] TAP_MAX   = '1;
    localparam logic [TAP_WIDTH-1:0] TAP_RESET = TAP_WIDTH'(DEFAULT_TAP);
    localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(NUM_LANES - 1);

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      apply_lane_q, apply_lane_d;
    logic                   apply_gap_q, apply_gap_d;
    logic [TAP_WIDTH-1:0]   shadow_q [NUM_LANES];
    logic [TAP_WIDTH-1:0]   shadow_d [NUM_LANES];
    logic [NUM_LANES-1:0]   ld_q, ld_d;
    logic [NUM_LANES-1:0]   ce_q, ce_d;
    logic                   inc_q, inc_d;
    logic                   sat_q, sat_d;
    logic                   err_q, err_d;
    logic                   settle_done;
    logic                   req_lane_ok;
    logic [NUM_LANES-1:0]   req_mask;
    op_e                    req_op;

`ifdef IDELAY_READBACK_EN
    logic [1:0]             verify_cnt_q, verify_cnt_d;
    logic [NUM_LANES-1:0]   verify_mask_q, verify_mask_d;
    logic                   readback_bad;
`else
    logic                   unused_cntvalueout;
    assign unused_cntvalueout = ^i_idelay_cntvalueout;
`endif

    idelay_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_rdy   (i_ictrl_rdy),
        .o_done  (settle_done)
    );

    // Lanes touched by the pending request; empty for an out-of-range lane.
    always_comb begin
        req_op      = op_e'(i_req_op);
        req_lane_ok = (req_op == OP_LOAD_ALL) || (32'(i_req_lane) < NUM_LANES);
        req_mask    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (req_op == OP_LOAD_ALL || LANE_W'(l) == i_req_lane) begin
                req_mask[l] = 1'b1;
            end
        end
    end

`ifdef IDELAY_READBACK_EN
    always_comb begin
        readback_bad = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (verify_mask_q[l] && i_idelay_cntvalueout[l*TAP_WIDTH +: TAP_WIDTH] != shadow_q[l]) begin
                readback_bad = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        apply_lane_d = apply_lane_q;
        apply_gap_d  = apply_gap_q;
        shadow_d     = shadow_q;
        ld_d         = '0;
        ce_d         = '0;
        inc_d        = inc_q;
        sat_d        = 1'b0;
        err_d        = 1'b0;
`ifdef IDELAY_READBACK_EN
        verify_cnt_d  = verify_cnt_q;
        verify_mask_d = verify_mask_q;
`endif
        if (!i_ictrl_rdy) begin
            state_d = ST_WAIT_RDY;
        end else begin
            case (state_q)
                ST_WAIT_RDY: state_d = ST_SETTLE;
                ST_SETTLE: begin
                    if (settle_done) begin
                        state_d      = ST_APPLY;
                        apply_lane_d = '0;
                        apply_gap_d  = 1'b0;
                        ld_d[0]      = 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (!apply_gap_q) begin
                        apply_gap_d = 1'b1;
                    end else if (apply_lane_q == LANE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        apply_lane_d = apply_lane_q + 1'b1;
                        apply_gap_d  = 1'b0;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (LANE_W'(l) == apply_lane_d) begin
                                ld_d[l] = 1'b1;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (i_req_valid) begin
                        state_d = ST_EXEC;
                        err_d   = !req_lane_ok;
`ifdef IDELAY_READBACK_EN
                        verify_mask_d = req_lane_ok ? req_mask : '0;
`endif
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (req_lane_ok && req_mask[l]) begin
                                case (req_op)
                                    OP_LOAD, OP_LOAD_ALL: begin
                                        shadow_d[l] = i_req_tap;
                                        ld_d[l]     = 1'b1;
                                    end
                                    OP_INC: begin
                                        if (shadow_q[l] == TAP_MAX) begin
                                            sat_d = 1'b1;
                                        end else begin
                                            shadow_d[l] = shadow_q[l] + 1'b1;
                                            ce_d[l]     = 1'b1;
                                            inc_d       = 1'b1;
                                        end
                                    end
                                    default: begin
                                        if (shadow_q[l] == '0) begin
                                            sat_d = 1'b1;
                                        end else begin
                                            shadow_d[l] = shadow_q[l] - 1'b1;
                                            ce_d[l]     = 1'b1;
                                            inc_d       = 1'b0;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end
                ST_EXEC: state_d = ST_GAP;
                ST_GAP: begin
`ifdef IDELAY_READBACK_EN
                    state_d      = ST_VERIFY;
                    verify_cnt_d = '0;
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef IDELAY_READBACK_EN
                ST_VERIFY: begin
                    // Compare is registered so the err pulse lands inside the final VERIFY cycle.
                    if (verify_cnt_q == 2'(VERIFY_WAIT - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        verify_cnt_d = verify_cnt_q + 1'b1;
                        err_d        = (verify_cnt_q == 2'(VERIFY_WAIT - 2)) && readback_bad;
                    end
                end
`endif
                default: state_d = ST_WAIT_RDY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_WAIT_RDY;
            apply_lane_q <= '0;
            apply_gap_q  <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                shadow_q[l] <= TAP_RESET;
            end
            ld_q  <= '0;
            ce_q  <= '0;
            inc_q <= 1'b0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
`ifdef IDELAY_READBACK_EN
            verify_cnt_q  <= '0;
            verify_mask_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            apply_lane_q <= apply_lane_d;
            apply_gap_q  <= apply_gap_d;
            shadow_q     <= shadow_d;
            ld_q         <= ld_d;
            ce_q         <= ce_d;
            inc_q        <= inc_d;
            sat_q        <= sat_d;
            err_q        <= err_d;
`ifdef IDELAY_READBACK_EN
            verify_cnt_q  <= verify_cnt_d;
            verify_mask_q <= verify_mask_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign o_idelay_cntvaluein[g*TAP_WIDTH +: TAP_WIDTH] = shadow_q[g];
        assign o_tap_shadow[g*TAP_WIDTH +: TAP_WIDTH]        = shadow_q[g];
    end

    assign o_req_ready  = (state_q == ST_IDLE) && i_ictrl_rdy;
    assign o_init_done  = (state_q == ST_IDLE) || (state_q == ST_EXEC) ||
                          (state_q == ST_GAP)  || (state_q == ST_VERIFY);
    assign o_idelay_ld  = ld_q;
    assign o_idelay_ce  = ce_q;
    assign o_idelay_inc = inc_q;
    assign o_sat        = sat_q;
    assign o_err        = err_q;

endmodule

// File: doc/rgmii_idelay_tap_ctrl.md
# rgmii_idelay_tap_ctrl

Runtime tap controller for a bank of `IDELAYE2` primitives in `VAR_LOAD` mode, replacing fixed-tap RGMII receive delays with per-lane programmable taps. It gates all tap activity on `IDELAYCTRL` ready and applies power-on default taps to every lane. It then serves single-lane load, increment and decrement requests, plus broadcast load requests, from a valid/ready request port. It sits between the RGMII receive delay bank and the board-level control logic in the Ethernet top level.

## Interface
- `NUM_LANES`, 5: number of delay lanes (RXD[3:0] plus RXCTL).
- `TAP_WIDTH`, 5: tap field width, matching the `IDELAYE2` CNTVALUE width.
- `DEFAULT_TAP`, 0: tap value applied at initialisation.
- `SETTLE_CYCLES`, 16: cycles `i_ictrl_rdy` must stay high before any load.
- `i_clk`  in  1  `IDELAYE2` C clock; all logic is on this edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_ictrl_rdy`  in  1  `IDELAYCTRL` RDY, already synchronised to `i_clk`.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request accept.
- `i_req_op`  in  2  request op: 00 LOAD, 01 INC, 10 DEC, 11 LOAD_ALL.
- `i_req_lane`  in  clog2(NUM_LANES)  target lane.
- `i_req_tap`  in  TAP_WIDTH  tap value for LOAD and LOAD_ALL.
- `o_idelay_ld`  out  NUM_LANES  per-lane LD strobe.
- `o_idelay_ce`  out  NUM_LANES  per-lane CE strobe.
- `o_idelay_inc`  out  1  shared INC direction.
- `o_idelay_cntvaluein`  out  NUM_LANES*TAP_WIDTH  per-lane CNTVALUEIN, driven from the shadow registers.
- `i_idelay_cntvalueout`  in  NUM_LANES*TAP_WIDTH  per-lane CNTVALUEOUT.
- `o_tap_shadow`  out  NUM_LANES*TAP_WIDTH  current shadow taps.
- `o_init_done`  out  1  high while taps are valid.
- `o_sat`  out  1  one-cycle pulse when an INC or DEC is refused.
- `o_err`  out  1  one-cycle pulse on an invalid lane or a readback mismatch.

## Operation
- Reset values:
  - State is WAIT_RDY.
  - Every shadow tap is `DEFAULT_TAP`.
  - All strobes are 0 and `o_idelay_inc` is 0.
  - `o_req_ready`, `o_init_done`, `o_sat` and `o_err` are all 0.
- States and transitions:
  - WAIT_RDY -> SETTLE when `i_ictrl_rdy` is 1.
  - SETTLE counts `SETTLE_CYCLES` consecutive rdy-high cycles, then goes to APPLY.
  - APPLY strobes LD on lanes 0..NUM_LANES-1 using the shadow values. Each lane gets LD for one cycle followed by one gap cycle, so APPLY lasts 2*NUM_LANES cycles. APPLY then goes to IDLE.
  - IDLE holds `o_req_ready`=1 and `o_init_done`=1.
  - From IDLE an accepted request goes to EXEC, then GAP, then back to IDLE.
- A loss of `i_ictrl_rdy` in any state forces WAIT_RDY on the next cycle:
  - strobes are cleared, `o_init_done` and `o_req_ready` drop, and any in-flight op is abandoned;
  - shadow values are retained and re-applied by APPLY, not reset to defaults.
- LOAD: the shadow tap for the lane takes `i_req_tap`; LD is strobed for that lane.
- LOAD_ALL: every shadow tap takes `i_req_tap`; LD is strobed for all lanes in the same cycle. `i_req_lane` is ignored.
- INC and DEC: CE is strobed with `o_idelay_inc` set to 1 or 0; the shadow tap moves by ±1.
  - Taps saturate: INC at 2^TAP_WIDTH-1 or DEC at 0 issues no CE, leaves the shadow unchanged, and pulses `o_sat`.
- A lane ≥ `NUM_LANES` (any op except LOAD_ALL) issues no strobe, changes no shadow, and pulses `o_err`.
- Only one op is in flight at a time. Requests are never queued.

## Timing
- A request is accepted at edge N when `i_req_valid` and `o_req_ready` are both 1.
- N+1 (EXEC):
  - exactly one of LD or CE is asserted for one cycle;
  - the shadow and `o_idelay_cntvaluein` update at this same edge;
  - `o_sat` and `o_err` pulse here.
- N+2 (GAP): `o_req_ready` is 0.
- N+3: `o_req_ready` returns to 1. Request throughput is therefore one per 3 cycles.
- `o_req_ready` is 0 during EXEC and GAP and in every non-IDLE state.
- Initialisation: `o_init_done` rises `SETTLE_CYCLES` + 2*NUM_LANES + 1 cycles after `i_ictrl_rdy` rises.

## Configuration
- `IDELAY_READBACK_EN` defined:
  - after GAP, a VERIFY state waits 2 cycles, then compares `i_idelay_cntvalueout` of the target lane (all lanes for LOAD_ALL) with the shadow;
  - a mismatch pulses `o_err` and leaves the shadow authoritative;
  - `o_req_ready` returns at N+5.
- `IDELAY_READBACK_EN` undefined: no VERIFY state, and `i_idelay_cntvalueout` is unused.

## Structure
- Package `idelay_ctrl_pkg` holds:
  - the state enum (WAIT_RDY, SETTLE, APPLY, IDLE, EXEC, GAP, VERIFY);
  - the op enum (`OP_LOAD`, `OP_INC`, `OP_DEC`, `OP_LOAD_ALL`);
  - the `VERIFY_WAIT` = 2 constant.
- One sub-module, `idelay_settle_timer`: a rdy-qualified down-counter that restarts on rdy low and asserts done at terminal count.

## Test plan
- Startup: release reset, rdy rises at cycle 10 -> LD pulses lanes 0..4 on alternate cycles from cycle 27 (value 0) -> `o_init_done` rises at cycle 37.
- LOAD lane 2 tap 17 -> `o_idelay_ld`=5'b00100 for one cycle, lane-2 CNTVALUEIN reads 17 -> ready returns 3 cycles after accept.
- Saturation: LOAD lane 0 tap 31, then INC lane 0 -> no CE, `o_sat` pulses, shadow stays 31. DEC at 0 -> same response.
- Invalid lane 6 LOAD -> `o_err` pulses, no strobes, shadows unchanged.
- Rdy loss: LOAD_ALL 9, drop rdy mid-GAP for 3 cycles -> `o_init_done` falls; after settle, APPLY reloads all lanes with 9.
- With `IDELAY_READBACK_EN`: LOAD lane 1 tap 12, CNTVALUEOUT for lane 1 held at 11 -> `o_err` pulses in VERIFY, ready at N+5.
